hack_alu_pipe: RTL and testbench
================================

// Module: hack_alu_pipe
// PURPOSE
//  Registered, parametrised Hack ALU with valid/ready handshakes on input and output.
//  Keeps the zx/nx/zy/ny/f/no control semantics and adds carry and overflow flags.
//  Supports output backpressure and an optional multi-cycle shift-add multiply.
//  Sits between the CPU decode stage and the D/A/M writeback path.
// PARAMETERS
//  WIDTH  16  operand/result width in bits (>=4)
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      operands + controls valid this cycle
//  in_ready   out  1      block can accept an operation
//  x, y       in   WIDTH  operands
//  zx,nx,zy,ny,f,no in 1 each  Hack control bits (sampled on accept)
//  mul        in   1      multiply request (see CONFIGURATION)
//  out_valid  out  1      result registers hold an unconsumed result
//  out_ready  in   1      consumer takes result this cycle
//  out        out  WIDTH  result
//  zr, ng     out  1      out==0 ; out[WIDTH-1]
//  cy, ov     out  1      unsigned carry-out ; signed overflow of the add
// BEHAVIOUR
//  - Accept when in_valid && in_ready. Result handoff when out_valid && out_ready.
//  - in_ready = (state==IDLE) && (!out_valid || out_ready). Zero-bubble throughput.
//  - Operand prep: xn = zx?0:x, then nx?~xn. yn is prepared from y the same way using zy/ny.
//  - f=1: r = xn+yn (WIDTH bits). cy = carry out of bit WIDTH-1.
//  - f=1: ov = (xn[MSB]==yn[MSB]) && (r[MSB]!=xn[MSB]).
//  - f=0: r = xn&yn, cy=ov=0.
//  - no=1: out = ~r. cy/ov are the pre-negation add flags.
//  - zr and ng are computed from the final out.
//  - Non-mul latency: accept on edge N -> out_valid=1 after edge N, result registered.
//  - Holding: while out_valid && !out_ready, out, zr, ng, cy and ov stay stable.
//  - Holding: in_ready=0 during this time.
//  - States: IDLE (single-cycle ops); MUL (iterating, only with HACK_ALU_MUL_EN).
//  - IDLE -> MUL on accept with mul=1.
//  - MUL -> IDLE after WIDTH iterations, loading the result registers with out_valid=1.
//  - A MUL result can only load when out is empty or consumed that cycle.
//  - If the output is still blocked, MUL stays in MUL with its counter at terminal.
//  - The MUL result is never dropped.
//  - Reset values: out_valid=0, out=0, zr=0, ng=0, cy=0, ov=0, state=IDLE, iteration count=0.
//  - in_ready becomes 1 on the first cycle after reset deasserts.
//  - Reset mid-MUL aborts the multiply; no result is produced.
//  - Reset while holding a result discards that result.
//  - Simultaneous handoff and accept in the same cycle: the new result replaces the old one.
//  - In that case out_valid stays 1.
//  - Width rules: all arithmetic is modulo 2^WIDTH. Products keep the low WIDTH bits only.
// CONFIGURATION
//  HACK_ALU_MUL_EN defined:
//   - mul=1 computes P = low WIDTH bits of xn*yn, using a shift-add loop, 1 bit per cycle.
//   - f is ignored; out = no ? ~P : P; cy=ov=0; zr/ng from out.
//   - Latency: WIDTH+1 cycles from the accept edge to out_valid.
//  HACK_ALU_MUL_EN undefined:
//   - mul is ignored (treated as 0), so every op is single-cycle.
//   - The MUL state and its counter are not synthesised.
// TESTING (WIDTH=16)
//  1. Add: x=5, y=3, ctl=000010 (f=1) -> out=8 one cycle after accept; zr=ng=cy=ov=0.
//  2. x-1 (zy=ny=f=1), x=0 -> out=0xFFFF, ng=1, zr=0, cy=0, ov=0.
//  3. x+y, x=0x7FFF, y=1 -> out=0x8000, ov=1, ng=1, cy=0.
//  4. x+y, x=0xFFFF, y=1 -> out=0x0000, zr=1, cy=1, ov=0.
//  5. Backpressure: out_ready=0 after op A, in_valid held with op B.
//     -> A's outputs stable, in_ready=0.
//     -> Raise out_ready: A consumed, B accepted that edge, B visible next cycle.
//  6. MUL_EN: x=7, y=6, mul=1 -> in_ready=0 for 17 cycles, out=42.
//     Repeat with reset pulsed at iteration 5 -> out_valid stays 0 and in_ready returns to 1.

Source files
------------

// File: rtl/hack_alu_pipe.sv
// Registered Hack ALU (zx/nx/zy/ny/f/no) with valid/ready handshakes, carry/overflow flags.
// Define HACK_ALU_MUL_EN to add a WIDTH-cycle shift-add multiply selected by mul.
module hack_alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    input  logic             mul,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             cy,
    output logic             ov
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_reg;
    logic             zr_reg, ng_reg, cy_reg, ov_reg;

    logic             out_free;
    logic             accept;
    logic [WIDTH-1:0] xn, yn;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_r, alu_out;
    logic             alu_cy, alu_ov;

    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_res;
    logic [WIDTH-1:0] res_out;

    assign out_free = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    // Zero then optionally invert each operand bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_prep
            assign xn[gi] = (x[gi] & ~zx) ^ nx;
            assign yn[gi] = (y[gi] & ~zy) ^ ny;
        end
    endgenerate

    assign sum     = {1'b0, xn} + {1'b0, yn};
    assign alu_r   = f ? sum[WIDTH-1:0] : (xn & yn);
    assign alu_cy  = f & sum[WIDTH];
    assign alu_ov  = f & (xn[WIDTH-1] == yn[WIDTH-1]) & (sum[WIDTH-1] != xn[WIDTH-1]);
    assign alu_out = no ? ~alu_r : alu_r;

`ifdef HACK_ALU_MUL_EN
    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH-1:0] mplier_reg, mplier_next;
    logic             mno_reg, mno_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            mno_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            mno_reg    <= mno_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        mno_next    = mno_reg;
        case (state_reg)
            IDLE: begin
                if (mul_start) begin
                    state_next  = MUL;
                    cnt_next    = '0;
                    acc_next    = '0;
                    mcand_next  = xn;
                    mplier_next = yn;
                    mno_next    = no;
                end
            end
            MUL: begin
                if (cnt_reg != CW'(WIDTH)) begin
                    if (mplier_reg[0]) begin
                        acc_next = acc_reg + mcand_reg;
                    end
                    mcand_next  = mcand_reg << 1;
                    mplier_next = mplier_reg >> 1;
                    cnt_next    = cnt_reg + CW'(1);
                end else if (out_free) begin
                    // Terminal count waits here until the output can take the product.
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == IDLE) && out_free;
    assign mul_start = accept && mul;
    assign mul_done  = (state_reg == MUL) && (cnt_reg == CW'(WIDTH)) && out_free;
    assign mul_res   = mno_reg ? ~acc_reg : acc_reg;
`else
    logic unused_mul;

    assign unused_mul = mul;
    assign in_ready   = out_free;
    assign mul_start  = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_res    = '0;
`endif

    assign res_out = mul_done ? mul_res : alu_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            zr_reg        <= 1'b0;
            ng_reg        <= 1'b0;
            cy_reg        <= 1'b0;
            ov_reg        <= 1'b0;
        end else if ((accept && !mul_start) || mul_done) begin
            out_valid_reg <= 1'b1;
            out_reg       <= res_out;
            zr_reg        <= (res_out == '0);
            ng_reg        <= res_out[WIDTH-1];
            cy_reg        <= mul_done ? 1'b0 : alu_cy;
            ov_reg        <= mul_done ? 1'b0 : alu_ov;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out       = out_reg;
    assign zr        = zr_reg;
    assign ng        = ng_reg;
    assign cy        = cy_reg;
    assign ov        = ov_reg;
endmodule

// File: tb/tb_hack_alu_pipe.sv
// Self-checking bench for hack_alu_pipe: vector table, handshake/reset sequences, randomized scoreboard.
module tb_hack_alu_pipe;
    localparam int W = 16;
`ifdef HACK_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] o;
        logic        zr;
        logic        ng;
        logic        cy;
        logic        ov;
    } res_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [5:0]  ctl;
        res_t        e;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready;
    logic [W-1:0]  x, y;
    logic          zx, nx, zy, ny, f, no, mul;
    logic          out_valid, out_ready;
    logic [W-1:0]  out;
    logic          zr, ng, cy, ov;

    int tests = 0;
    int fails = 0;

    hack_alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .mul(mul),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .zr(zr), .ng(ng), .cy(cy), .ov(ov)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c, input logic m);
        x = a;
        y = b;
        {zx, nx, zy, ny, f, no} = c;
        mul = m;
    endtask

    // Reference: plain integer arithmetic on the Hack rules.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic [5:0] c, input logic m);
        longint unsigned xv, yv, s, r;
        longint sx, sy, ss;
        res_t res;
        xv = c[5] ? 0 : a;
        if (c[4]) xv = 65535 - xv;
        yv = c[3] ? 0 : b;
        if (c[2]) yv = 65535 - yv;
        res.cy = 1'b0;
        res.ov = 1'b0;
        if (m && MUL_EN) begin
            r = (xv * yv) % 65536;
        end else if (c[1]) begin
            s = xv + yv;
            r = s % 65536;
            res.cy = (s >= 65536);
            sx = (xv >= 32768) ? longint'(xv) - 65536 : longint'(xv);
            sy = (yv >= 32768) ? longint'(yv) - 65536 : longint'(yv);
            ss = sx + sy;
            res.ov = (ss > 32767) || (ss < -32768);
        end else begin
            r = xv & yv;
        end
        if (c[0]) r = 65535 - r;
        res.o  = 16'(r);
        res.zr = (r == 0);
        res.ng = (r >= 32768);
        return res;
    endfunction

    task automatic apply_check(input string name, input logic [15:0] a, input logic [15:0] b,
                               input logic [5:0] c, input logic m, input res_t e, input int exp_lat);
        int n;
        int lat;
        @(negedge clk);
        drive(a, b, c, m);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk({name, "_accept_timeout"}, 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        mul      = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_out"}, out, e.o);
        chk({name, "_zr"}, zr, e.zr);
        chk({name, "_ng"}, ng, e.ng);
        chk({name, "_cy"}, cy, e.cy);
        chk({name, "_ov"}, ov, e.ov);
        $display("[TB] %s x=%h y=%h ctl=%b mul=%0b -> out=%h zr=%0b ng=%0b cy=%0b ov=%0b lat=%0d",
                 name, a, b, c, m, out, zr, ng, cy, ov, lat);
    endtask

    vec_t vecs[10];
    res_t q[$];

    initial begin
        res_t e;
        logic pending;
        logic [15:0] rx, ry;
        logic [5:0] rc;
        logic rm;
        logic seen;
        int busy, n;

        // ctl order: {zx, nx, zy, ny, f, no}
        vecs[0] = '{16'd5,    16'd3,    6'b000010, '{16'h0008, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{16'd0,    16'h1234, 6'b001110, '{16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[2] = '{16'h7FFF, 16'h0001, 6'b000010, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b1}};
        vecs[3] = '{16'hFFFF, 16'h0001, 6'b000010, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}};
        vecs[4] = '{16'hF0F0, 16'h3C3C, 6'b000000, '{16'h3030, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[5] = '{16'h00FF, 16'h5555, 6'b001101, '{16'hFF00, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[6] = '{16'h1234, 16'h4321, 6'b101010, '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[7] = '{16'h1234, 16'h4321, 6'b111010, '{16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[8] = '{16'd3,    16'd5,    6'b010011, '{16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0}};
        vecs[9] = '{16'h8000, 16'h8000, 6'b000010, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b1}};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(16'h0, 16'h0, 6'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out", out, 0);
        chk("reset_flags", {zr, ng, cy, ov}, 0);
        reset = 1'b0;
        #1;
        chk("reset_in_ready", in_ready, 1);
        $display("[TB] reset: out_valid=%0b out=%h in_ready=%0b", out_valid, out, in_ready);

        foreach (vecs[i]) begin
            apply_check($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].ctl, 1'b0, vecs[i].e, 1);
        end

`ifndef HACK_ALU_MUL_EN
        apply_check("mul_ignored", 16'd7, 16'd6, 6'b000010, 1'b1, '{16'd13, 1'b0, 1'b0, 1'b0, 1'b0}, 1);
`endif

        // Backpressure: A held, B waits, then zero-bubble swap.
        @(negedge clk);
        drive(16'd5, 16'd3, 6'b000010, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        drive(16'h7FFF, 16'h0001, 6'b000010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_out", out, 16'd8);
            chk("bp_hold_flags", {zr, ng, cy, ov}, 0);
            chk("bp_hold_in_ready", in_ready, 0);
            $display("[TB] hold cycle %0d: out=%h in_ready=%0b", i, out, in_ready);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_b_valid", out_valid, 1);
        chk("bp_b_out", out, 16'h8000);
        chk("bp_b_ov_ng", {ov, ng}, 2'b11);
        $display("[TB] swap: B out=%h ov=%0b ng=%0b", out, ov, ng);
        @(negedge clk);
        chk("bp_drained", out_valid, 0);

        // Reset while a result is held discards it.
        drive(16'd1, 16'd1, 6'b000010, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_hold_pre", out, 16'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_hold_valid", out_valid, 0);
        chk("rst_hold_out", out, 0);
        chk("rst_hold_in_ready", in_ready, 1);
        $display("[TB] reset-while-holding: out_valid=%0b out=%h", out_valid, out);

`ifdef HACK_ALU_MUL_EN
        @(negedge clk);
        drive(16'd7, 16'd6, 6'b000010, 1'b1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mul_accept", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        mul      = 1'b0;
        busy     = 0;
        n        = 0;
        while (!out_valid && n < 100) begin
            if (!in_ready) busy++;
            n++;
            @(negedge clk);
        end
        chk("mul_busy_cycles", busy, W + 1);
        chk("mul_out", out, 16'd42);
        chk("mul_flags", {zr, ng, cy, ov}, 0);
        $display("[TB] mul 7*6: out=%0d busy=%0d", out, busy);
        @(negedge clk);

        drive(16'd7, 16'd6, 6'b000010, 1'b1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        mul      = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mul_abort_in_ready", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        chk("mul_abort_no_result", seen, 0);
        $display("[TB] mul aborted by reset: result_seen=%0b", seen);
`endif

        // Randomized stream with random backpressure against the model.
        pending = 1'b0;
        rx = '0; ry = '0; rc = '0; rm = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            out_ready = ($urandom_range(3) != 0);
            if (!pending && ($urandom_range(1) == 1)) begin
                rx = 16'($urandom);
                ry = 16'($urandom);
                rc = 6'($urandom);
                rm = MUL_EN ? ($urandom_range(7) == 0) : 1'($urandom_range(1));
                pending = 1'b1;
            end
            in_valid = pending;
            drive(rx, ry, rc, rm);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_spurious_result", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rand_result", {out, zr, ng, cy, ov}, e);
                    $display("[TB] rand handoff: out=%h flags=%b expected=%h/%b",
                             out, {zr, ng, cy, ov}, e.o, {e.zr, e.ng, e.cy, e.ov});
                end
            end
`ifndef HACK_ALU_MUL_EN
            chk("rand_in_ready", in_ready, !out_valid || out_ready);
`endif
            if (in_valid && in_ready) begin
                q.push_back(model(rx, ry, rc, rm));
                pending = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 100 && (q.size() != 0); c++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                e = q.pop_front();
                chk("drain_result", {out, zr, ng, cy, ov}, e);
                $display("[TB] drain handoff: out=%h", out);
            end
        end
        chk("drain_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
